// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks fetch-time predictions to EX, flags mispredicts, drives redirect/flush and BTB updates.
// Optional statistics counters are built only when BRU_STATS_EN is defined.
module branch_resolve_unit #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned DRAIN_CYC = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STALL,
    input  logic              PRED_VALID_IF,
    input  logic              PRED_TAKEN_IF,
    input  logic [ADDR_W-1:0] PRED_TGT_IF,
    input  logic [ADDR_W-1:0] PC_IF,
    input  logic              BR_VALID_EX,
    input  logic              BR_TAKEN_EX,
    input  logic [ADDR_W-1:0] BR_TGT_EX,
    input  logic [ADDR_W-1:0] PC_EX,
    input  logic [ADDR_W-1:0] PC_1_EX,
    output logic              REDIRECT,
    output logic [ADDR_W-1:0] REDIRECT_PC,
    output logic              UPD_VALID,
    output logic [ADDR_W-1:0] UPD_PC,
    output logic [ADDR_W-1:0] UPD_TGT,
    output logic              UPD_TAKEN,
    output logic              BUSY,
    output logic [CNT_W-1:0]  BR_CNT,
    output logic [CNT_W-1:0]  MISPRED_CNT
);

    localparam int unsigned DC_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        REDIR = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic              v;
        logic              taken;
        logic [ADDR_W-1:0] tgt;
        logic [ADDR_W-1:0] pc;
    } shadow_t;

    state_t            state_q, state_d;
    logic [DC_W-1:0]   drain_q, drain_d;
    shadow_t           shadow_q [DEPTH];
    shadow_t           shadow_d [DEPTH];
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              upd_valid_q, upd_valid_d;
    logic [ADDR_W-1:0] upd_pc_q, upd_pc_d;
    logic [ADDR_W-1:0] upd_tgt_q, upd_tgt_d;
    logic              upd_taken_q, upd_taken_d;
    logic              busy_q, busy_d;

    shadow_t           oldest;
    logic              hit;
    logic              sample;
    logic              mispred;
    logic [ADDR_W-1:0] fix_pc;

    // Compare the oldest shadow entry against the resolving branch.
    always_comb begin
        oldest  = shadow_q[DEPTH-1];
        hit     = oldest.v && (oldest.pc == PC_EX);
        sample  = BR_VALID_EX && !STALL && (state_q == TRACK);
        mispred = 1'b0;
        fix_pc  = BR_TGT_EX;
        if (sample) begin
            if (hit && oldest.taken) begin
                if (!BR_TAKEN_EX) begin
                    mispred = 1'b1;
                    fix_pc  = PC_1_EX;
                end else if (oldest.tgt != BR_TGT_EX) begin
                    mispred = 1'b1;
                end
            end else if (BR_TAKEN_EX) begin
                mispred = 1'b1;
            end
        end
    end

    // Next state, shadow shift/flush and registered outputs.
    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        shadow_d      = shadow_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_tgt_d     = upd_tgt_q;
        upd_taken_d   = upd_taken_q;

        case (state_q)
            TRACK: begin
                if (mispred) begin
                    state_d       = REDIR;
                    redirect_d    = 1'b1;
                    redirect_pc_d = fix_pc;
                end
            end
            REDIR: begin
                state_d = DRAIN;
                drain_d = DRAIN_LOAD;
            end
            DRAIN: begin
                if (!STALL) begin
                    if (drain_q == '0) begin
                        state_d = TRACK;
                    end else begin
                        drain_d = drain_q - DC_W'(1);
                    end
                end
            end
            default: state_d = TRACK;
        endcase

        if (sample) begin
            upd_valid_d = 1'b1;
            upd_pc_d    = PC_EX;
            upd_tgt_d   = BR_TGT_EX;
            upd_taken_d = BR_TAKEN_EX;
        end

        // Wrong-path entries and the IF input are discarded while the redirect pulse is out.
        if (state_q == REDIR) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                shadow_d[i] = '0;
            end
        end else if (!STALL) begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                shadow_d[i] = shadow_q[i-1];
            end
            shadow_d[0] = {PRED_VALID_IF, PRED_TAKEN_IF, PRED_TGT_IF, PC_IF};
        end

        busy_d = (state_d != TRACK);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= TRACK;
            drain_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_tgt_q     <= '0;
            upd_taken_q   <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_tgt_q     <= upd_tgt_d;
            upd_taken_q   <= upd_taken_d;
            busy_q        <= busy_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // Saturating resolution / mispredict counters.
    always_comb begin
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (sample && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BR_CNT      = br_cnt_q;
    assign MISPRED_CNT = mispred_cnt_q;
`else
    assign BR_CNT      = '0;
    assign MISPRED_CNT = '0;
`endif

    assign REDIRECT    = redirect_q;
    assign REDIRECT_PC = redirect_pc_q;
    assign UPD_VALID   = upd_valid_q;
    assign UPD_PC      = upd_pc_q;
    assign UPD_TGT     = upd_tgt_q;
    assign UPD_TAKEN   = upd_taken_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand-written corner sequences, random run against a queue-based model.
module tb_branch_resolve_unit;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DEPTH     = 3;
    localparam int unsigned DRAIN_CYC = 3;
    localparam int unsigned CNT_W     = 8;
`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              CLK, RST, STALL;
    logic              PRED_VALID_IF, PRED_TAKEN_IF;
    logic [ADDR_W-1:0] PRED_TGT_IF, PC_IF;
    logic              BR_VALID_EX, BR_TAKEN_EX;
    logic [ADDR_W-1:0] BR_TGT_EX, PC_EX, PC_1_EX;
    logic              REDIRECT, UPD_VALID, UPD_TAKEN, BUSY;
    logic [ADDR_W-1:0] REDIRECT_PC, UPD_PC, UPD_TGT;
    logic [CNT_W-1:0]  BR_CNT, MISPRED_CNT;

    branch_resolve_unit #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL),
        .PRED_VALID_IF(PRED_VALID_IF), .PRED_TAKEN_IF(PRED_TAKEN_IF),
        .PRED_TGT_IF(PRED_TGT_IF), .PC_IF(PC_IF),
        .BR_VALID_EX(BR_VALID_EX), .BR_TAKEN_EX(BR_TAKEN_EX),
        .BR_TGT_EX(BR_TGT_EX), .PC_EX(PC_EX), .PC_1_EX(PC_1_EX),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .UPD_VALID(UPD_VALID), .UPD_PC(UPD_PC), .UPD_TGT(UPD_TGT), .UPD_TAKEN(UPD_TAKEN),
        .BUSY(BUSY), .BR_CNT(BR_CNT), .MISPRED_CNT(MISPRED_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        v;
        logic        taken;
        logic [15:0] tgt;
        logic [15:0] pc;
    } ent_t;

    ent_t        shq[$];
    bit          m_redir;
    int          m_drain;
    int          m_br, m_mis;
    logic        e_redir, e_updv, e_updtk, e_busy;
    logic [15:0] e_rpc, e_updpc, e_updtgt;

    task automatic model_reset();
        ent_t z;
        z = '{1'b0, 1'b0, 16'h0, 16'h0};
        shq.delete();
        for (int i = 0; i < int'(DEPTH); i++) shq.push_back(z);
        m_redir = 0; m_drain = 0; m_br = 0; m_mis = 0;
        e_redir = 0; e_updv = 0; e_updtk = 0; e_busy = 0;
        e_rpc = 0; e_updpc = 0; e_updtgt = 0;
    endtask

    // Predicted next fetch vs actual next fetch, with the taken bit itself also compared.
    task automatic model_step();
        ent_t        e, ne, z;
        logic        smp, ptk, mis;
        logic [15:0] actual_next;
        z  = '{1'b0, 1'b0, 16'h0, 16'h0};
        e  = shq[DEPTH-1];
        smp = !m_redir && (m_drain == 0) && BR_VALID_EX && !STALL;
        ptk = e.v && (e.pc == PC_EX) && e.taken;
        mis = (ptk != BR_TAKEN_EX) || (BR_TAKEN_EX && ptk && (e.tgt != BR_TGT_EX));
        actual_next = BR_TAKEN_EX ? BR_TGT_EX : PC_1_EX;
        e_updv = smp;
        if (smp) begin
            e_updpc = PC_EX; e_updtgt = BR_TGT_EX; e_updtk = BR_TAKEN_EX;
            if (m_br < 255) m_br++;
            if (mis && m_mis < 255) m_mis++;
        end
        if (m_redir) begin
            m_redir = 0;
            m_drain = DRAIN_CYC;
            for (int i = 0; i < int'(DEPTH); i++) shq[i] = z;
        end else begin
            if (m_drain > 0 && !STALL) m_drain--;
            if (!STALL) begin
                ne = '{PRED_VALID_IF, PRED_TAKEN_IF, PRED_TGT_IF, PC_IF};
                void'(shq.pop_back());
                shq.push_front(ne);
            end
            if (smp && mis) begin
                m_redir = 1;
                e_rpc   = actual_next;
            end
        end
        e_redir = m_redir;
        e_busy  = m_redir || (m_drain > 0);
    endtask

    task automatic check_all();
        chk("redirect",    32'(REDIRECT),    32'(e_redir));
        chk("redirect_pc", 32'(REDIRECT_PC), 32'(e_rpc));
        chk("upd_valid",   32'(UPD_VALID),   32'(e_updv));
        chk("upd_pc",      32'(UPD_PC),      32'(e_updpc));
        chk("upd_tgt",     32'(UPD_TGT),     32'(e_updtgt));
        chk("upd_taken",   32'(UPD_TAKEN),   32'(e_updtk));
        chk("busy",        32'(BUSY),        32'(e_busy));
        chk("br_cnt",      32'(BR_CNT),      STATS ? 32'(m_br) : 32'd0);
        chk("mispred_cnt", 32'(MISPRED_CNT), STATS ? 32'(m_mis) : 32'd0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        STALL = 0; PRED_VALID_IF = 0; PRED_TAKEN_IF = 0; PRED_TGT_IF = 0; PC_IF = 0;
        BR_VALID_EX = 0; BR_TAKEN_EX = 0; BR_TGT_EX = 0; PC_EX = 0; PC_1_EX = 0;
    endtask

    task automatic do_reset();
        set_idle();
        RST = 1'b1;
        #2;
        chk("rst_redirect",  32'(REDIRECT),    32'd0);
        chk("rst_rpc",       32'(REDIRECT_PC), 32'd0);
        chk("rst_upd_valid", 32'(UPD_VALID),   32'd0);
        chk("rst_upd_pc",    32'(UPD_PC),      32'd0);
        chk("rst_busy",      32'(BUSY),        32'd0);
        chk("rst_br_cnt",    32'(BR_CNT),      32'd0);
        chk("rst_mis_cnt",   32'(MISPRED_CNT), 32'd0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        stall, pv, pt;
        logic [15:0] ptgt, pcif;
        logic        bv, bt;
        logic [15:0] btgt, pcex, pc1;
        logic        redir;
        logic [15:0] rpc;
        logic        updv;
        logic [15:0] updpc;
        logic        updtk, busy;
        int          brc, misc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic pv, input logic pt, input logic [15:0] ptgt,
                                input logic [15:0] pcif, input logic bv, input logic bt, input logic [15:0] btgt,
                                input logic [15:0] pcex, input logic [15:0] pc1, input logic redir,
                                input logic [15:0] rpc, input logic updv, input logic [15:0] updpc,
                                input logic updtk, input logic busy, input int brc, input int misc);
        vec_t v;
        v = '{s, pv, pt, ptgt, pcif, bv, bt, btgt, pcex, pc1, redir, rpc, updv, updpc, updtk, busy, brc, misc};
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int busy_n, redir_n;
        RST = 1'b1;
        set_idle();

        //              s pv pt ptgt     pcif     bv bt btgt     pcex     pc1       rd rpc      uv updpc   tk bsy brc mis
        tbl[0]  = mk(0, 1, 1, 16'h0040, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0040, 16'h0010, 16'h0011, 0, 16'h0000, 1, 16'h0010, 1, 0, 1, 0);
        tbl[4]  = mk(0, 1, 1, 16'h0099, 16'h0020, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0010, 1, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0010, 1, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0010, 1, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0099, 16'h0020, 16'h0021, 1, 16'h0021, 1, 16'h0020, 0, 1, 2, 1);
        tbl[8]  = mk(0, 1, 1, 16'h0005, 16'h0050, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0021, 0, 16'h0020, 0, 1, 2, 1);
        tbl[9]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0077, 16'h0050, 16'h0051, 0, 16'h0021, 0, 16'h0020, 0, 1, 2, 1);
        tbl[10] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0021, 0, 16'h0020, 0, 1, 2, 1);
        tbl[11] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0021, 0, 16'h0020, 0, 0, 2, 1);
        tbl[12] = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0005, 16'h0030, 16'h0031, 1, 16'h0005, 1, 16'h0030, 1, 1, 3, 2);

        do_reset();
        for (int r = 0; r < 13; r++) begin
            STALL = tbl[r].stall; PRED_VALID_IF = tbl[r].pv; PRED_TAKEN_IF = tbl[r].pt;
            PRED_TGT_IF = tbl[r].ptgt; PC_IF = tbl[r].pcif;
            BR_VALID_EX = tbl[r].bv; BR_TAKEN_EX = tbl[r].bt; BR_TGT_EX = tbl[r].btgt;
            PC_EX = tbl[r].pcex; PC_1_EX = tbl[r].pc1;
            @(posedge CLK);
            #1;
            chk($sformatf("tbl_redirect[%0d]", r),  32'(REDIRECT),    32'(tbl[r].redir));
            chk($sformatf("tbl_rpc[%0d]", r),       32'(REDIRECT_PC), 32'(tbl[r].rpc));
            chk($sformatf("tbl_upd_valid[%0d]", r), 32'(UPD_VALID),   32'(tbl[r].updv));
            chk($sformatf("tbl_upd_pc[%0d]", r),    32'(UPD_PC),      32'(tbl[r].updpc));
            chk($sformatf("tbl_upd_taken[%0d]", r), 32'(UPD_TAKEN),   32'(tbl[r].updtk));
            chk($sformatf("tbl_busy[%0d]", r),      32'(BUSY),        32'(tbl[r].busy));
            chk($sformatf("tbl_br_cnt[%0d]", r),    32'(BR_CNT),      STATS ? 32'(tbl[r].brc) : 32'd0);
            chk($sformatf("tbl_mis_cnt[%0d]", r),   32'(MISPRED_CNT), STATS ? 32'(tbl[r].misc) : 32'd0);
        end

        // Stall held between predict and resolve: entry must survive and match.
        do_reset();
        PRED_VALID_IF = 1; PRED_TAKEN_IF = 1; PRED_TGT_IF = 16'h0080; PC_IF = 16'h0060;
        cycle();
        set_idle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            STALL = 1; PRED_VALID_IF = 1; PC_IF = 16'h0061;
            BR_VALID_EX = 1; BR_TAKEN_EX = 1; BR_TGT_EX = 16'h0080; PC_EX = 16'h0060; PC_1_EX = 16'h0061;
            cycle();
            chk("stall_no_upd", 32'(UPD_VALID), 32'd0);
        end
        set_idle();
        cycle();
        BR_VALID_EX = 1; BR_TAKEN_EX = 1; BR_TGT_EX = 16'h0080; PC_EX = 16'h0060; PC_1_EX = 16'h0061;
        cycle();
        chk("stall_match_redirect", 32'(REDIRECT), 32'd0);
        chk("stall_match_upd",      32'(UPD_VALID), 32'd1);
        chk("stall_match_upd_pc",   32'(UPD_PC), 32'h0060);

        // Mispredict; stall on the REDIR cycle and two DRAIN cycles; BR_VALID in DRAIN is ignored.
        BR_VALID_EX = 1; BR_TAKEN_EX = 1; BR_TGT_EX = 16'h0033; PC_EX = 16'h0090; PC_1_EX = 16'h0091;
        cycle();
        chk("drain_redirect_pc", 32'(REDIRECT_PC), 32'h0033);
        busy_n  = int'(BUSY);
        redir_n = int'(REDIRECT);
        for (int i = 0; i < 12; i++) begin
            set_idle();
            STALL = (i == 0 || i == 2 || i == 3);
            if (i == 1) begin
                BR_VALID_EX = 1; BR_TAKEN_EX = 1; BR_TGT_EX = 16'h0044; PC_EX = 16'h00A0; PC_1_EX = 16'h00A1;
            end
            cycle();
            busy_n  += int'(BUSY);
            redir_n += int'(REDIRECT);
        end
        chk("drain_busy_cycles",  32'(busy_n),  32'(1 + DRAIN_CYC + 2));
        chk("drain_redirect_len", 32'(redir_n), 32'd1);

        // Continuous mispredicts to saturate the counters.
        do_reset();
        BR_VALID_EX = 1; BR_TAKEN_EX = 1; BR_TGT_EX = 16'h1234; PC_EX = 16'h0ABC; PC_1_EX = 16'h0ABD;
        for (int i = 0; i < 1600; i++) cycle();
        chk("mis_sat", 32'(MISPRED_CNT), STATS ? 32'hFF : 32'd0);
        chk("br_sat",  32'(BR_CNT),      STATS ? 32'hFF : 32'd0);

        // Asynchronous reset in the middle of DRAIN.
        k = 0;
        while (!REDIRECT && k < 10) begin
            cycle();
            k++;
        end
        chk("saw_redirect", 32'(REDIRECT), 32'd1);
        set_idle();
        PRED_VALID_IF = 1; PRED_TAKEN_IF = 1; PRED_TGT_IF = 16'h0071; PC_IF = 16'h0070;
        cycle();
        cycle();
        chk("busy_before_rst", 32'(BUSY), 32'd1);
        do_reset();
        BR_VALID_EX = 1; BR_TAKEN_EX = 1; BR_TGT_EX = 16'h0071; PC_EX = 16'h0070; PC_1_EX = 16'h0071;
        cycle();
        chk("post_rst_upd",      32'(UPD_VALID), 32'd1);
        chk("post_rst_redirect", 32'(REDIRECT),  32'd1);

        // Random run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ent_t o;
            o = shq[DEPTH-1];
            STALL         = ($urandom_range(0, 4) == 0);
            PRED_VALID_IF = $urandom_range(0, 1) == 1;
            PRED_TAKEN_IF = $urandom_range(0, 1) == 1;
            PRED_TGT_IF   = 16'($urandom_range(0, 3) * 16);
            PC_IF         = 16'($urandom_range(0, 15));
            BR_VALID_EX   = $urandom_range(0, 1) == 1;
            BR_TAKEN_EX   = $urandom_range(0, 1) == 1;
            PC_EX         = ($urandom_range(0, 3) != 0) ? o.pc : 16'($urandom_range(0, 15));
            BR_TGT_EX     = ($urandom_range(0, 3) != 0) ? o.tgt : 16'($urandom_range(0, 3) * 16);
            PC_1_EX       = PC_EX + 16'd1;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
